// File: rtl/cpu_pkg.sv
// Shared definitions for the front-panel control unit: sizes, opcode values,
// instruction field positions, FSM state type and the 7-bit immediate sign-extender.
package cpu_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned INSTR_W  = 18;
  localparam int unsigned OP_W     = 3;

  localparam logic [OP_W-1:0] OP_LOAD    = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD     = 3'd1;
  localparam logic [OP_W-1:0] OP_ADDI    = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB     = 3'd3;
  localparam logic [OP_W-1:0] OP_SUBI    = 3'd4;
  localparam logic [OP_W-1:0] OP_MUL     = 3'd5;
  localparam logic [OP_W-1:0] OP_CLEAR   = 3'd6;
  localparam logic [OP_W-1:0] OP_DISPLAY = 3'd7;

  // Field positions; rs2 and imm7 overlap on bit 6 by design of the encoding.
  localparam int unsigned OP_MSB  = 17;
  localparam int unsigned OP_LSB  = 15;
  localparam int unsigned RD_MSB  = 14;
  localparam int unsigned RD_LSB  = 12;
  localparam int unsigned RS1_MSB = 11;
  localparam int unsigned RS1_LSB = 9;
  localparam int unsigned RS2_MSB = 8;
  localparam int unsigned RS2_LSB = 6;
  localparam int unsigned IMM_MSB = 6;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StWb
  } state_e;

  function automatic logic [DATA_W-1:0] sext7(input logic [6:0] imm);
    return {{(DATA_W - 7){imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/module_register_file.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port,
// and a single-cycle clear of every entry.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (all entries to 0)
//   i_clear_all          zero every entry on the next rising edge (wins over write)
//   i_we/i_waddr/i_wdata synchronous write port
//   i_raddr1/o_rdata1    asynchronous read port 1
//   i_raddr2/o_rdata2    asynchronous read port 2
module module_register_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear_all,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_clear_all) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/module_control_unit.sv
// Front-panel sequencer driving the combinational ALU. A send-button press in IDLE
// captures the switch word; the instruction then walks DECODE -> EXEC -> WB, one
// cycle each, and LOAD/CLEAR/DISPLAY are completed locally without the ALU.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   send_button     raw asynchronous button level (synchronised inside)
//   instruction     18-bit switch word, sampled only on capture
//   alu_result      saturated ALU result, valid in the same cycle as the operands
//   alu_a/alu_b     registered ALU operands, held from EXEC until the next EXEC
//   alu_opcode      registered ALU opcode (0 for LOAD)
//   display_value   last DISPLAY selection or last written-back value
//   busy            high from capture until the FSM returns to IDLE
//   instr_done      one-cycle pulse during WB
module module_control_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               send_button,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_opcode,
  output logic [DATA_W-1:0]  display_value,
  output logic               busy,
  output logic               instr_done
);

  // Button synchroniser and rising-edge detect.
  logic r_sync1, r_sync2, r_btn_prev;
  logic w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_sync1    <= send_button;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_btn_prev;

  state_e             r_state, w_state_next;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_alu_a, r_alu_b, r_result, r_display;
  logic [OP_W-1:0]    r_alu_op;

  logic [OP_W-1:0]   w_op;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rdata1, w_rdata2;

  assign w_op  = r_instr[OP_MSB:OP_LSB];
  assign w_rd  = r_instr[RD_MSB:RD_LSB];
  assign w_rs1 = r_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = r_instr[RS2_MSB:RS2_LSB];
  assign w_imm = sext7(r_instr[IMM_MSB:IMM_LSB]);

  logic              w_capture, w_load_ops, w_latch_res;
  logic              w_we, w_clear, w_disp_en;
  logic [DATA_W-1:0] w_wdata, w_disp_next;
  logic [DATA_W-1:0] w_alu_a_next, w_alu_b_next;
  logic [OP_W-1:0]   w_alu_op_next;

  // Operands are registered on the DECODE->EXEC edge so the ALU sees them for the
  // whole EXEC cycle; the result is registered on the EXEC->WB edge.
  always_comb begin
    w_alu_a_next  = w_rdata1;
    w_alu_b_next  = ((w_op == OP_ADDI) || (w_op == OP_SUBI)) ? w_imm : w_rdata2;
    w_alu_op_next = (w_op == OP_LOAD) ? OP_LOAD : w_op;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load_ops   = 1'b0;
    w_latch_res  = 1'b0;
    w_we         = 1'b0;
    w_wdata      = r_result;
    w_clear      = 1'b0;
    w_disp_en    = 1'b0;
    w_disp_next  = r_display;

    case (r_state)
      StIdle: begin
        if (w_press) begin
          w_capture    = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        w_load_ops   = 1'b1;
        w_state_next = StExec;
      end
      StExec: begin
        w_latch_res  = 1'b1;
        w_state_next = StWb;
      end
      StWb: begin
        w_state_next = StIdle;
        case (w_op)
          OP_LOAD: begin
            w_we    = 1'b1;
            w_wdata = w_imm;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL: begin
            w_we    = 1'b1;
            w_wdata = r_result;
          end
          OP_CLEAR: begin
            w_clear     = 1'b1;
            w_disp_en   = 1'b1;
            w_disp_next = '0;
          end
          default: begin
            // DISPLAY: nothing is written, so the async read is still current.
            w_disp_en   = 1'b1;
            w_disp_next = w_rdata1;
          end
        endcase
        if (w_we) begin
          w_disp_en   = 1'b1;
          w_disp_next = w_wdata;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_instr   <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_result  <= '0;
      r_display <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_instr <= instruction;
      if (w_load_ops) begin
        r_alu_a  <= w_alu_a_next;
        r_alu_b  <= w_alu_b_next;
        r_alu_op <= w_alu_op_next;
      end
      if (w_latch_res) r_result <= alu_result;
      if (w_disp_en) r_display <= w_disp_next;
    end
  end

  module_register_file u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear_all(w_clear),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (w_wdata),
    .i_raddr1   (w_rs1),
    .o_rdata1   (w_rdata1),
    .i_raddr2   (w_rs2),
    .o_rdata2   (w_rdata2)
  );

  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_opcode    = r_alu_op;
  assign display_value = r_display;
  assign busy          = (r_state != StIdle);
  assign instr_done    = (r_state == StWb);

endmodule
